// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder: operation encoding
// and the parameter legality check used at elaboration.
package csa_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // True when the segment/stage split is legal: the segments tile the word
   // exactly and every stage owns the same whole number of segments.
   function automatic bit csa_cfg_ok(input int width, input int block, input int stages);
      bit ok;
      ok = 1'b1;
      if (block < 2 || width < block || stages < 1) begin
         ok = 1'b0;
      end else if ((width % block) != 0) begin
         ok = 1'b0;
      end else if (((width / block) % stages) != 0) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select segment: two ripple sums (carry-in 0 and 1) computed in
// parallel, with the late-arriving carry picking the result. Purely combinational.
module csa_block #(
   parameter int BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             c_sel,
   output logic [BLOCK-1:0] s,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [BLOCK:0] sum0;
   logic [BLOCK:0] sum1;

   assign sum0 = {1'b0, a} + {1'b0, b};
   assign sum1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

   assign s     = c_sel ? sum1[BLOCK-1:0] : sum0[BLOCK-1:0];
   assign c_out = c_sel ? sum1[BLOCK]     : sum0[BLOCK];

   // The top sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out
   // of the selected sum without tapping the ripple chain.
   assign c_msb_in = s[BLOCK-1] ^ a[BLOCK-1] ^ b[BLOCK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Stage k resolves its own group of segments using the carry registered by
// stage k-1; operands still waiting for their segments and the sum bits
// already resolved ride along in each stage register.
module csa_pipe_adder
   import csa_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int NBLK = (WIDTH / BLOCK < 1) ? 1 : WIDTH / BLOCK;
   localparam int NPS  = (NBLK / STAGES < 1) ? 1 : NBLK / STAGES;
   localparam int SW   = NPS * BLOCK;

   if (!csa_cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_err
      $error("csa_pipe_adder: illegal WIDTH/BLOCK/STAGES combination");
   end

   op_e              op;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   logic [STAGES-1:0] v_all;
   logic [STAGES-1:0] adv;

   // Subtraction is a + ~b + ~borrow_in: fold the inversion in at the entry so
   // every stage is a plain adder and the op travels implicitly with the beat.
   assign op    = op_e'(sub);
   assign b_eff = (op == OP_SUB) ? ~b : b;
   assign c_eff = (op == OP_SUB) ? ~c_in : c_in;

   // Advance chain from the output back: a stage moves when it is empty or the
   // stage after it moves, so bubbles are always filled.
   always_comb begin
      adv = '0;
      adv[STAGES-1] = ~v_all[STAGES-1] | out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k] = ~v_all[k] | adv[k+1];
      end
   end

   assign in_ready = adv[0];

   genvar gi, gj;
   for (gi = 0; gi < STAGES; gi++) begin : g_stg
      logic [WIDTH-1:0] a_src, b_src, s_src;
      logic             c_src, v_src;
      logic [WIDTH-1:0] a_reg, b_reg, s_reg;
      logic             c_reg, ovf_reg, v_reg;
      logic [WIDTH-1:0] s_next;
      logic [SW-1:0]    seg_s;
      logic             c_next, ovf_next;
      logic             stage_unused;

      if (gi == 0) begin : g_first
         assign a_src = a;
         assign b_src = b_eff;
         assign c_src = c_eff;
         assign v_src = in_valid;
         assign s_src = '0;
      end else begin : g_later
         assign a_src = g_stg[gi-1].a_reg;
         assign b_src = g_stg[gi-1].b_reg;
         assign c_src = g_stg[gi-1].c_reg;
         assign v_src = g_stg[gi-1].v_reg;
         assign s_src = g_stg[gi-1].s_reg;
      end

      for (gj = 0; gj < NPS; gj++) begin : g_blk
         logic cin_w, cout_w, cmsb_w;

         if (gj == 0) begin : g_cin_stage
            assign cin_w = c_src;
         end else begin : g_cin_chain
            assign cin_w = g_blk[gj-1].cout_w;
         end

         csa_block #(
            .BLOCK(BLOCK)
         ) u_blk (
            .a        (a_src[(gi*NPS + gj)*BLOCK +: BLOCK]),
            .b        (b_src[(gi*NPS + gj)*BLOCK +: BLOCK]),
            .c_sel    (cin_w),
            .s        (seg_s[gj*BLOCK +: BLOCK]),
            .c_out    (cout_w),
            .c_msb_in (cmsb_w)
         );
      end

      assign c_next = g_blk[NPS-1].cout_w;

      // Overflow only has meaning at the MSB, which lives in the last stage.
      if (gi == STAGES - 1) begin : g_ovf
         assign ovf_next = g_blk[NPS-1].cmsb_w ^ g_blk[NPS-1].cout_w;
      end else begin : g_no_ovf
         assign ovf_next = 1'b0;
      end

      // Splice this stage's freshly resolved segments into the running sum.
      always_comb begin
         s_next = s_src;
         s_next[gi*SW +: SW] = seg_s;
      end

      // Stage register: loads on advance, otherwise holds data and valid.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_reg   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            s_reg   <= '0;
            c_reg   <= 1'b0;
            ovf_reg <= 1'b0;
         end else if (adv[gi]) begin
            v_reg   <= v_src;
            a_reg   <= a_src;
            b_reg   <= b_src;
            s_reg   <= s_next;
            c_reg   <= c_next;
            ovf_reg <= ovf_next;
         end
      end

      assign v_all[gi] = v_reg;

      // Already-consumed operand bits and non-final overflow are dead here.
      assign stage_unused = ^{a_reg, b_reg, ovf_reg};
   end

   assign out_valid = g_stg[STAGES-1].v_reg;
   assign s         = g_stg[STAGES-1].s_reg;
   assign c_out     = g_stg[STAGES-1].c_reg;
   assign ovf       = g_stg[STAGES-1].ovf_reg;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Self-checking bench for csa_pipe_adder: directed arithmetic cases, latency,
// stalled streaming, asynchronous reset and a random scoreboard run.
module tb_csa_pipe_adder;

   localparam int WIDTH  = 32;
   localparam int BLOCK  = 8;
   localparam int STAGES = 2;
   localparam int NBEAT  = 10000;
   localparam int BUDGET = 60000;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             o;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             sub = 1'b0;
   logic             c_in = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] s;
   logic             c_out;
   logic             ovf;

   int   checks = 0;
   int   failures = 0;
   int   popped = 0;
   exp_t sb[$];

   csa_pipe_adder #(
      .WIDTH (WIDTH),
      .BLOCK (BLOCK),
      .STAGES(STAGES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .c_in     (c_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s),
      .c_out    (c_out),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain integer add, or subtract with borrow.
   function automatic exp_t model(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                  input logic sub_i, input logic c_i);
      logic [WIDTH:0] r;
      exp_t e;
      if (!sub_i) begin
         r   = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, c_i};
         e.c = r[WIDTH];
         e.o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (r[WIDTH-1] != a_i[WIDTH-1]);
      end else begin
         r   = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, c_i};
         e.c = ~r[WIDTH];
         e.o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (r[WIDTH-1] != a_i[WIDTH-1]);
      end
      e.s = r[WIDTH-1:0];
      return e;
   endfunction

   function automatic logic [WIDTH-1:0] rand_word();
      logic [63:0]      r;
      logic [WIDTH-1:0] w;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: w = '0;
         1: w = '1;
         2: begin w = '0; w[WIDTH-1] = 1'b1; end
         3: begin w = '1; w[WIDTH-1] = 1'b0; end
         4: w = {{(WIDTH-1){1'b0}}, 1'b1};
         default: w = r[WIDTH-1:0];
      endcase
      return w;
   endfunction

   // Monitor: scoreboard push/pop, ready model and stall stability, sampled
   // on the falling edge when everything has settled.
   initial begin
      logic             stall_prev;
      logic [WIDTH-1:0] s_prev;
      logic             c_prev, o_prev, exp_rdy;
      exp_t             e;
      stall_prev = 1'b0;
      s_prev = '0; c_prev = 1'b0; o_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               checks++;
               if (out_valid !== 1'b1 || s !== s_prev || c_out !== c_prev || ovf !== o_prev) begin
                  failures++;
                  $display("FAIL stall_hold: got v=%b s=%h c=%b o=%b want v=1 s=%h c=%b o=%b",
                           out_valid, s, c_out, ovf, s_prev, c_prev, o_prev);
               end
            end
            exp_rdy = (sb.size() < STAGES) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
               failures++;
               $display("FAIL in_ready: got %b want %b (in flight %0d, out_ready %b)",
                        in_ready, exp_rdy, sb.size(), out_ready);
            end
            if (out_valid && out_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_out: got s=%h with no beat in flight", s);
               end else begin
                  e = sb.pop_front();
                  popped++;
                  if (s !== e.s || c_out !== e.c || ovf !== e.o) begin
                     failures++;
                     $display("FAIL sb_data: got s=%h c=%b o=%b want s=%h c=%b o=%b",
                              s, c_out, ovf, e.s, e.c, e.o);
                  end
               end
            end
            if (in_valid && in_ready) begin
               sb.push_back(model(a, b, sub, c_in));
            end
            stall_prev = out_valid && !out_ready;
            s_prev = s; c_prev = c_out; o_prev = ovf;
         end
      end
   end

   // Presents one beat (caller is at posedge+1) and returns after its accept edge +1.
   task automatic send_beat(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                            input logic sub_i, input logic c_i, output bit ok);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      a = a_i; b = b_i; sub = sub_i; c_in = c_i; in_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      ok = acc;
   endtask

   task automatic drain(input int budget, output bit ok);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      ok = (sb.size() == 0);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || s !== '0 || c_out !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: got v=%b s=%h c=%b o=%b rdy=%b want v=0 s=0 c=0 o=0 rdy=1",
                  out_valid, s, c_out, ovf, in_ready);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_latency();
      bit ok;
      int n;
      out_ready = 1'b1;
      send_beat(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, ok);
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (!ok || n != STAGES) begin
         failures++;
         $display("FAIL latency: got %0d cycles (accepted %b) want %0d", n, ok, STAGES);
      end
      checks++;
      if (s !== 32'h0 || c_out !== 1'b1 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL wrap_ffff: got s=%h c=%b o=%b want s=00000000 c=1 o=0", s, c_out, ovf);
      end
      drain(20, ok);
   endtask

   task automatic test_directed();
      logic [31:0] ta [5] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h5, 32'h7};
      logic [31:0] tb [5] = '{32'h1, 32'h1, 32'h1, 32'h7, 32'h5};
      logic        tsub [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] ts [5] = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h1};
      logic        tco [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic        tov [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      bit ok;
      int n;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_beat(ta[i], tb[i], tsub[i], tc[i], ok);
         n = 0;
         while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
         end
         checks++;
         if (s !== ts[i] || c_out !== tco[i] || ovf !== tov[i] || !out_valid) begin
            failures++;
            $display("FAIL directed_%0d: got v=%b s=%h c=%b o=%b want s=%h c=%b o=%b",
                     i, out_valid, s, c_out, ovf, ts[i], tco[i], tov[i]);
         end
         drain(20, ok);
      end
   endtask

   task automatic test_back_to_back();
      int  idx, cyc, start;
      bit  acc, ok;
      idx = 0;
      cyc = 0;
      start = popped;
      while (idx < 8 && cyc < 200) begin
         out_ready = (cyc % 2) == 0;
         a = WIDTH'(32'h1000_0000 * idx + 32'h0123_4567);
         b = WIDTH'(32'hF00D_0000 + idx);
         sub = idx[0];
         c_in = idx[1];
         in_valid = 1'b1;
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain(50, ok);
      checks++;
      if (popped - start != 8 || !ok) begin
         failures++;
         $display("FAIL back_to_back_count: got %0d results want 8", popped - start);
      end
   endtask

   task automatic test_async_reset();
      bit ok1, ok2, ok;
      int start;
      out_ready = 1'b0;
      send_beat(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, ok1);
      send_beat(32'h0F0F_0F0F, 32'h1, 1'b1, 1'b0, ok2);
      checks++;
      if (!ok1 || !ok2 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL async_prefill: got v=%b acc=%b%b want v=1 acc=11", out_valid, ok1, ok2);
      end
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      checks++;
      if (out_valid !== 1'b0 || s !== '0 || c_out !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset: got v=%b s=%h c=%b rdy=%b want v=0 s=0 c=0 rdy=1",
                  out_valid, s, c_out, in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stale_beat: got out_valid=%b s=%h want out_valid=0", out_valid, s);
         end
      end
      start = popped;
      send_beat(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b1, ok1);
      send_beat(32'h0000_0003, 32'h0000_0009, 1'b1, 1'b1, ok2);
      drain(20, ok);
      checks++;
      if (popped - start != 2 || !ok) begin
         failures++;
         $display("FAIL post_reset_count: got %0d results want 2", popped - start);
      end
   endtask

   task automatic test_random();
      int  sent, n, start;
      bit  pend, ok;
      sent = 0;
      n = 0;
      pend = 1'b0;
      start = popped;
      while (sent < NBEAT && n < BUDGET) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pend) begin
            if ($urandom_range(0, 3) != 0) begin
               a = rand_word();
               b = rand_word();
               sub = 1'($urandom);
               c_in = 1'($urandom);
               in_valid = 1'b1;
               pend = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            sent++;
            pend = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain(50, ok);
      checks++;
      if (sent != NBEAT || popped - start != NBEAT || !ok) begin
         failures++;
         $display("FAIL random_count: got sent=%0d results=%0d want %0d each",
                  sent, popped - start, NBEAT);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_directed();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
